// File: rtl/tia_clk_axil_slave.sv
// AXI4-Lite register slave that programs and generates a divided TIA measurement clock.
// Latency: AW/W accepted 1 cycle after both valid, BVALID 1 cycle later; ARVALID->RVALID 2 cycles.
// Backpressure: B and R are held until BREADY/RREADY; no new write accepted while BVALID is high.
//
// Ports: ACLK/ARESETN (async active-low), S_AXI_* AXI4-Lite slave (32-bit data, 4-bit byte
// address, four word registers), tia_clk generated clock, tia_busy generator running.
// Optional feature macro TIA_CLK_IRQ_EN: adds the irq output and CTRL bit3 IRQ_EN.
//
// Register map (byte address):
//   0x0 CTRL   bit0 EN, bit1 ONESHOT, bit2 START (write-1 pulse, reads 0), bit3 IRQ_EN (macro only)
//   0x4 DIV    [DIV_WIDTH-1:0] half-period minus one
//   0x8 NCYC   periods per oneshot burst
//   0xC STATUS bit0 BUSY, bit1 DONE (sticky, write 1 to clear), [31:16] periods completed (saturating)
module tia_clk_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int DIV_WIDTH          = 16
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic                              tia_clk,
`ifdef TIA_CLK_IRQ_EN
    output logic                              irq,
`endif
    output logic                              tia_busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                 aw_rdy_q, aw_rdy_d;
    logic                 bvalid_q, bvalid_d;
    logic                 ar_rdy_q, ar_rdy_d;
    logic                 rvalid_q, rvalid_d;
    logic [31:0]          rdata_q, rdata_d;

    logic                 ctrl_en_q, ctrl_en_d;
    logic                 ctrl_oneshot_q, ctrl_oneshot_d;
    logic                 start_q, start_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [31:0]          ncyc_q, ncyc_d;
    logic                 done_q, done_d;
`ifdef TIA_CLK_IRQ_EN
    logic                 ctrl_irq_en_q, ctrl_irq_en_d;
    logic                 irq_q, irq_d;
`endif

    logic [1:0]           state_q, state_d;
    logic [DIV_WIDTH-1:0] hcnt_q, hcnt_d;
    logic [DIV_WIDTH-1:0] div_act_q, div_act_d;
    logic [31:0]          ncyc_act_q, ncyc_act_d;
    logic [31:0]          pcnt_q, pcnt_d;
    logic                 tia_clk_q, tia_clk_d;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[b*8 +: 8] = new_val[b*8 +: 8];
            end
        end
        return res;
    endfunction

    logic        wr_fire, rd_fire;
    logic [1:0]  wr_idx, rd_idx;
    logic [31:0] reg_rd [4];
    logic [31:0] wr_merged;
    logic        done_set, done_clr;
    logic [15:0] pcnt_sat;
    logic        unused_ok;

    assign wr_idx  = S_AXI_AWADDR[3:2];
    assign rd_idx  = S_AXI_ARADDR[3:2];
    assign wr_fire = aw_rdy_q & S_AXI_AWVALID & S_AXI_WVALID;
    assign rd_fire = ar_rdy_q & S_AXI_ARVALID;

    // Protection bits and the byte offset within a word carry no meaning here.
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign pcnt_sat = (|pcnt_q[31:16]) ? 16'hFFFF : pcnt_q[15:0];

    // Read view of every register; also the base value for strobed writes.
    always_comb begin
        reg_rd[0] = '0;
        reg_rd[0][0] = ctrl_en_q;
        reg_rd[0][1] = ctrl_oneshot_q;
`ifdef TIA_CLK_IRQ_EN
        reg_rd[0][3] = ctrl_irq_en_q;
`endif
        reg_rd[1] = '0;
        reg_rd[1][DIV_WIDTH-1:0] = div_q;
        reg_rd[2] = ncyc_q;
        reg_rd[3] = {pcnt_sat, 14'd0, done_q, (state_q == ST_RUN)};
    end

    assign wr_merged = strb_merge(reg_rd[wr_idx], S_AXI_WDATA, S_AXI_WSTRB);

    // ------------------------------------------------------------------
    // AXI handshakes
    // ------------------------------------------------------------------
    always_comb begin
        // One-cycle ready pulse; the ~aw_rdy_q term keeps the accept cycle from re-arming.
        aw_rdy_d = S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q & ~aw_rdy_q;
        bvalid_d = bvalid_q;
        if (bvalid_q && S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end
        if (wr_fire) begin
            bvalid_d = 1'b1;
        end

        ar_rdy_d = S_AXI_ARVALID & ~rvalid_q & ~ar_rdy_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
        if (rd_fire) begin
            // Captures current register contents, so a same-cycle write is not yet visible.
            rvalid_d = 1'b1;
            rdata_d  = reg_rd[rd_idx];
        end
    end

    // ------------------------------------------------------------------
    // Register writes
    // ------------------------------------------------------------------
    always_comb begin
        ctrl_en_d      = ctrl_en_q;
        ctrl_oneshot_d = ctrl_oneshot_q;
        start_d        = 1'b0;
        div_d          = div_q;
        ncyc_d         = ncyc_q;
        done_clr       = 1'b0;
`ifdef TIA_CLK_IRQ_EN
        ctrl_irq_en_d  = ctrl_irq_en_q;
`endif
        if (wr_fire) begin
            case (wr_idx)
                2'd0: begin
                    ctrl_en_d      = wr_merged[0];
                    ctrl_oneshot_d = wr_merged[1];
                    start_d        = wr_merged[2];
`ifdef TIA_CLK_IRQ_EN
                    ctrl_irq_en_d  = wr_merged[3];
`endif
                end
                2'd1: div_d  = wr_merged[DIV_WIDTH-1:0];
                2'd2: ncyc_d = wr_merged;
                default: done_clr = S_AXI_WSTRB[0] & S_AXI_WDATA[1];
            endcase
        end

        // A completion in the same cycle as a clear wins so the event is not lost.
        done_d = done_q;
        if (done_clr) begin
            done_d = 1'b0;
        end
        if (done_set) begin
            done_d = 1'b1;
        end
    end

`ifdef TIA_CLK_IRQ_EN
    assign irq_d = done_q & ctrl_irq_en_q;
`endif

    // ------------------------------------------------------------------
    // Clock generator
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        hcnt_d     = hcnt_q;
        div_act_d  = div_act_q;
        ncyc_act_d = ncyc_act_q;
        pcnt_d     = pcnt_q;
        tia_clk_d  = tia_clk_q;
        done_set   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tia_clk_d = 1'b0;
                hcnt_d    = '0;
                if (ctrl_en_q && (!ctrl_oneshot_q || (start_q && (ncyc_q != '0)))) begin
                    state_d    = ST_RUN;
                    pcnt_d     = '0;
                    div_act_d  = div_q;
                    ncyc_act_d = ncyc_q;
                end
            end
            ST_RUN: begin
                if (hcnt_q == div_act_q) begin
                    hcnt_d    = '0;
                    tia_clk_d = ~tia_clk_q;
                    // DIV/NCYC updates are only picked up here, at a wrap.
                    div_act_d  = div_q;
                    ncyc_act_d = ncyc_q;
                    if (tia_clk_q) begin
                        // Falling toggle closes one full period.
                        pcnt_d = (pcnt_q == '1) ? pcnt_q : pcnt_q + 32'd1;
                        if (ctrl_oneshot_q && (pcnt_d >= ncyc_act_q)) begin
                            state_d   = ST_HOLD;
                            tia_clk_d = 1'b0;
                            done_set  = 1'b1;
                        end
                    end
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            ST_HOLD: begin
                tia_clk_d = 1'b0;
                state_d   = ST_IDLE;
            end
            default: begin
                tia_clk_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase

        // Clearing EN stops the generator from any state; DONE is left alone.
        if (!ctrl_en_q) begin
            state_d   = ST_IDLE;
            tia_clk_d = 1'b0;
            hcnt_d    = '0;
        end
    end

    // ------------------------------------------------------------------
    // Flops
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_rdy_q       <= 1'b0;
            bvalid_q       <= 1'b0;
            ar_rdy_q       <= 1'b0;
            rvalid_q       <= 1'b0;
            rdata_q        <= '0;
            ctrl_en_q      <= 1'b0;
            ctrl_oneshot_q <= 1'b0;
            start_q        <= 1'b0;
            div_q          <= '0;
            ncyc_q         <= '0;
            done_q         <= 1'b0;
            state_q        <= ST_IDLE;
            hcnt_q         <= '0;
            div_act_q      <= '0;
            ncyc_act_q     <= '0;
            pcnt_q         <= '0;
            tia_clk_q      <= 1'b0;
        end else begin
            aw_rdy_q       <= aw_rdy_d;
            bvalid_q       <= bvalid_d;
            ar_rdy_q       <= ar_rdy_d;
            rvalid_q       <= rvalid_d;
            rdata_q        <= rdata_d;
            ctrl_en_q      <= ctrl_en_d;
            ctrl_oneshot_q <= ctrl_oneshot_d;
            start_q        <= start_d;
            div_q          <= div_d;
            ncyc_q         <= ncyc_d;
            done_q         <= done_d;
            state_q        <= state_d;
            hcnt_q         <= hcnt_d;
            div_act_q      <= div_act_d;
            ncyc_act_q     <= ncyc_act_d;
            pcnt_q         <= pcnt_d;
            tia_clk_q      <= tia_clk_d;
        end
    end

`ifdef TIA_CLK_IRQ_EN
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ctrl_irq_en_q <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            ctrl_irq_en_q <= ctrl_irq_en_d;
            irq_q         <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign S_AXI_AWREADY = aw_rdy_q;
    assign S_AXI_WREADY  = aw_rdy_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_ARREADY = ar_rdy_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RVALID  = rvalid_q;
    assign tia_clk       = tia_clk_q;
    assign tia_busy      = (state_q == ST_RUN);

endmodule

// File: tb/tb_tia_clk_axil_slave.sv
// Directed bench for tia_clk_axil_slave: register access, generator timing, oneshot burst,
// strobes, write backpressure and mid-run reset. Inputs driven and outputs sampled on negedge.
module tb_tia_clk_axil_slave;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [3:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        tia_clk, tia_busy;
`ifdef TIA_CLK_IRQ_EN
    logic        irq;
`endif

    always #5 ACLK = ~ACLK;

    tia_clk_axil_slave dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .tia_clk       (tia_clk),
`ifdef TIA_CLK_IRQ_EN
        .irq           (irq),
`endif
        .tia_busy      (tia_busy)
    );

    int checks = 0;
    int failures = 0;

    // Free-running activity counters on the generator outputs.
    int   rise_cnt = 0;
    int   high_cnt = 0;
    int   busy_cnt = 0;
    logic clk_prev = 1'b0;

    always @(negedge ACLK) begin
        if (tia_clk && !clk_prev) rise_cnt++;
        if (tia_clk) high_cnt++;
        if (tia_busy) busy_cnt++;
        clk_prev = tia_clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int t;
        @(negedge ACLK);
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        t = 0;
        while (!bvalid && t < 20) begin
            @(negedge ACLK);
            t++;
        end
        check("wr_b_latency", t, 2);
        check("wr_bresp", {30'd0, bresp}, 0);
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge ACLK);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
        int t;
        @(negedge ACLK);
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        t = 0;
        while (!rvalid && t < 20) begin
            @(negedge ACLK);
            t++;
        end
        check("rd_latency", t, 2);
        check("rd_rresp", {30'd0, rresp}, 0);
        data = rdata;
        arvalid = 1'b0;
        @(negedge ACLK);
        rready = 1'b0;
    endtask

    task automatic wait_lvl(input logic lvl, output int n);
        n = 0;
        while (tia_clk !== lvl && n < 200) begin
            @(negedge ACLK);
            n++;
        end
    endtask

    logic [31:0] rd, a, b;
    int n, h, l, t, r0, h0, b0;

    initial begin
        ARESETN = 1'b0;
        awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        wdata = '0; wstrb = '0;
        repeat (3) @(negedge ACLK);

        // Reset state
        check("rst_awready", awready, 0);
        check("rst_wready", wready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_arready", arready, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_tia_clk", tia_clk, 0);
        check("rst_tia_busy", tia_busy, 0);
        ARESETN = 1'b1;

        // Basic register write / readback
        axi_write(4'h0, 32'h1, 4'hF);
        axi_write(4'h4, 32'h2, 4'hF);
        axi_write(4'h8, 32'h3, 4'hF);
        axi_write(4'hC, 32'h4, 4'hF);
        axi_read(4'h0, rd); check("rb_ctrl", rd, 32'h1);
        axi_read(4'h4, rd); check("rb_div", rd, 32'h2);
        axi_read(4'h8, rd); check("rb_ncyc", rd, 32'h3);
        // EN=1 free-run is active, so BUSY=1 and DONE=0; the period count is free-moving.
        axi_read(4'hC, rd); check("rb_status_lo", {16'd0, rd[15:0]}, 32'h1);
        axi_write(4'h0, 32'h0, 4'hF);

        // Free-running clock, DIV=4 -> 5 high + 5 low
        axi_write(4'h4, 32'h4, 4'hF);
        axi_write(4'h0, 32'h1, 4'hF);
        wait_lvl(1'b1, n); wait_lvl(1'b0, n); wait_lvl(1'b1, n);
        wait_lvl(1'b0, h); wait_lvl(1'b1, l);
        check("free_high", h, 5);
        check("free_low", l, 5);
        check("free_busy", tia_busy, 1);
        wait_lvl(1'b0, n);
        axi_read(4'hC, a);
        wait_lvl(1'b1, n); wait_lvl(1'b0, n);
        axi_read(4'hC, b);
        check("stat_busy", {30'd0, a[1:0]}, 32'h1);
        check("stat_pcnt_step", {16'd0, b[31:16] - a[31:16]}, 32'h1);

        // EN=0 stops the generator
        axi_write(4'h0, 32'h0, 4'hF);
        @(negedge ACLK);
        check("stop_busy", tia_busy, 0);
        check("stop_clk", tia_clk, 0);

        // Oneshot burst: DIV=0, NCYC=3
        axi_write(4'h4, 32'h0, 4'hF);
        axi_write(4'h8, 32'h3, 4'hF);
        axi_write(4'h0, 32'h3, 4'hF);
        @(negedge ACLK);
        check("os_armed_idle", tia_busy, 0);
        r0 = rise_cnt; h0 = high_cnt; b0 = busy_cnt;
        axi_write(4'h0, 32'h7, 4'hF);
        repeat (20) @(negedge ACLK);
        check("os_rises", rise_cnt - r0, 3);
        check("os_high_cycles", high_cnt - h0, 3);
        check("os_busy_cycles", busy_cnt - b0, 6);
        axi_read(4'hC, rd); check("os_status", rd, 32'h0003_0002);
        axi_read(4'h0, rd); check("os_ctrl_start_rd0", rd, 32'h3);
        axi_write(4'hC, 32'h2, 4'hF);
        axi_read(4'hC, rd); check("done_clear", rd, 32'h0003_0000);

        // START with NCYC=0 is ignored
        axi_write(4'h8, 32'h0, 4'hF);
        r0 = rise_cnt;
        axi_write(4'h0, 32'h7, 4'hF);
        repeat (4) @(negedge ACLK);
        check("start_ncyc0_busy", tia_busy, 0);
        check("start_ncyc0_rises", rise_cnt - r0, 0);

        // Byte strobes
        axi_write(4'h8, 32'hFFFF_FFFF, 4'b0001);
        axi_read(4'h8, rd); check("wstrb_lane0", rd, 32'h0000_00FF);

        // Read and write to DIV in the same cycle: read sees the old value
        @(negedge ACLK);
        awaddr = 4'h4; wdata = 32'hABCD_1234; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
        araddr = 4'h4; arvalid = 1; rready = 1;
        t = 0;
        while (!rvalid && t < 20) begin
            @(negedge ACLK);
            t++;
        end
        rd = rdata;
        check("simul_bvalid", bvalid, 1);
        awvalid = 0; wvalid = 0; arvalid = 0;
        @(negedge ACLK);
        bready = 0; rready = 0;
        check("simul_old_val", rd, 32'h0);
        axi_read(4'h4, rd); check("simul_new_div", rd, 32'h0000_1234);

        // BREADY held low: B stays valid and a second write is not accepted
        @(negedge ACLK);
        awaddr = 4'h4; wdata = 32'h7; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
        t = 0;
        while (!bvalid && t < 20) begin
            @(negedge ACLK);
            t++;
        end
        awaddr = 4'h8; wdata = 32'h9;
        n = 0;
        repeat (5) begin
            @(negedge ACLK);
            if (bvalid && !awready) n++;
        end
        check("b_hold_no_accept", n, 5);
        bready = 1;
        @(negedge ACLK);
        check("b_handshake_done", bvalid, 0);
        t = 0;
        while (!bvalid && t < 20) begin
            @(negedge ACLK);
            t++;
        end
        check("b_second_write", bvalid, 1);
        awvalid = 0; wvalid = 0;
        @(negedge ACLK);
        bready = 0;
        axi_read(4'h4, rd); check("bp_first_data", rd, 32'h7);
        axi_read(4'h8, rd); check("bp_second_data", rd, 32'h9);

        // Reset mid-run, with a write in flight
        axi_write(4'h4, 32'h1, 4'hF);
        axi_write(4'h0, 32'h1, 4'hF);
        repeat (6) @(negedge ACLK);
        check("pre_rst_busy", tia_busy, 1);
        @(negedge ACLK);
        awaddr = 4'h8; wdata = 32'h55; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
        t = 0;
        while (!awready && t < 20) begin
            @(negedge ACLK);
            t++;
        end
        ARESETN = 1'b0;
        awvalid = 0; wvalid = 0;
        repeat (3) @(negedge ACLK);
        check("mid_rst_clk", tia_clk, 0);
        check("mid_rst_busy", tia_busy, 0);
        check("mid_rst_valids", {28'd0, awready, bvalid, arready, rvalid}, 32'h0);
`ifdef TIA_CLK_IRQ_EN
        check("mid_rst_irq", irq, 0);
`endif
        ARESETN = 1'b1;
        bready = 1;
        n = 0;
        repeat (4) begin
            @(negedge ACLK);
            if (bvalid) n++;
        end
        bready = 0;
        check("no_b_after_rst", n, 0);
        axi_read(4'h0, rd); check("post_rst_ctrl", rd, 32'h0);
        axi_read(4'h4, rd); check("post_rst_div", rd, 32'h0);
        axi_read(4'h8, rd); check("post_rst_ncyc", rd, 32'h0);
        axi_read(4'hC, rd); check("post_rst_status", rd, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
